aes_128_dec: RTL and testbench
==============================

# aes_128_dec

Iterative AES-128 decryptor: the receive-side counterpart to the pipelined AES-128 encryptor. It expands a loaded key once into a stored round-key table, then decrypts one 128-bit ciphertext block at a time, one round per clock. Blocks enter and leave through valid/ready handshakes. Its output must bit-match the plaintext that was fed to the encryptor under the same key.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key  in  128  cipher key K0; sampled only on the accepted key_load cycle.
- key_load  in  1  pulse; starts key expansion when accepted.
- key_ready  out  1  round-key table is valid and no expansion is in progress.
- in_valid  in  1  ciphertext block on in_bus is offered.
- in_ready  out  1  block can be accepted; = (state==IDLE) & ~key_load.
- in_bus  in  128  ciphertext block.
- out_valid  out  1  out_bus holds a finished plaintext block.
- out_ready  in  1  consumer accepts out_bus.
- out_bus  out  128  plaintext; stable while out_valid=1 and out_ready=0.

## Operation
- States:
  - NOKEY: no valid key.
  - EXPAND: key schedule running.
  - IDLE: key valid, waiting for a block.
  - ROUND: decrypting.
  - DONE: holding the result.
- Key expansion:
  - An accepted key_load (in NOKEY or IDLE) writes rk[0]<=key, sets rcon=0x01 and round counter=1, and enters EXPAND.
  - Each EXPAND cycle writes rk[i] <= key_schedule(rk[i-1], {rcon,24'h0}). Reuse the existing key_schedule block.
  - After each write, rcon <= xtime(rcon). The rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
  - After rk[10] is written (10 EXPAND cycles): go to IDLE and set key_ready=1.
- key_load is ignored in EXPAND, ROUND and DONE. No abort, no queueing.
- Block accept: in_valid & in_ready in IDLE sets state <= in_bus ^ rk[10] and round counter r=9, then enters ROUND.
- In ROUND, each cycle applies InvShiftRows, then InvSubBytes, then XOR with rk[r]:
  - If r>0, also apply InvMixColumns and decrement r.
  - If r==0, load the result into out_bus, set out_valid=1 and enter DONE.
- In DONE, out_valid & out_ready clears out_valid and returns to IDLE. There is no same-cycle re-accept.
- The inverse S-box comes from the shared aes_inv_sbox cell (16 instances, combinational). InvMixColumns is local combinational GF(2^8) logic using the coefficients 0e/0b/0d/09.
- Byte order: bit 127:120 is byte 0 (column-major, FIPS-197), the same convention as the encryptor.
- key_load and in_valid high together in IDLE: key_load wins, in_ready=0, the block is not transferred.
- in_valid in NOKEY or EXPAND: in_ready=0, the block is held off.

## Timing
- Reset values:
  - state=NOKEY.
  - key_ready=0, in_ready=0, out_valid=0.
  - out_bus=0, round-key table=0, counters=0.
- Key expansion: key_ready rises 10 cycles after the key_load accept edge (visible after edge 10).
- Decrypt latency: out_valid rises after the 10th rising edge following the accept edge.
- Minimum block period: 12 cycles (accept, 10 ROUND cycles, 1 DONE cycle with out_ready=1).
- Reset asserted mid-expansion or mid-round:
  - All outputs go to their reset values immediately.
  - The partial result is discarded.
  - After reset, key_ready=0 and a new key_load is required.
- out_ready held low: stay in DONE indefinitely, out_bus unchanged, in_ready=0.
- Reloading the key in IDLE invalidates the table: key_ready=0 until the new expansion completes.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, with out_valid exactly 10 cycles after accept and key_ready exactly 10 cycles after key_load.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734. Then, without reloading the key, decrypt the C.1-style block again -> correct result with back-to-back 12-cycle spacing.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_bus stable, in_ready=0, a second in_valid is not accepted. Release -> transfer, then the next block is accepted.
- Ignored/priority events:
  - in_valid before any key_load -> in_ready=0.
  - key_load pulsed during ROUND -> ignored, result still correct for the old key.
  - key_load with in_valid in IDLE -> no transfer, expansion starts.
- Reset mid-round: assert rst_n=0 at round 5 -> out_valid=0, key_ready=0, in_ready=0 immediately. Reload the key, redo C.1 -> correct.
- Round trip: 1000 random key/plaintext pairs through the aes_128 encryptor, then into this block -> output equals the original plaintext.

Source files
------------

// File: rtl/aes_128_dec.sv
// Iterative AES-128 decryptor: one-shot key expansion into a round-key table,
// then one inverse round per clock with valid/ready block handshakes.

package aes_128_dec_pkg;
    localparam int unsigned BLK_W = 128;
    localparam int unsigned NR    = 10;
    localparam int unsigned RND_W = 4;

    typedef enum logic [2:0] {
        S_NOKEY,
        S_EXPAND,
        S_IDLE,
        S_ROUND,
        S_DONE
    } dec_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction
endpackage

// Forward S-box: field inverse followed by the affine transform
module aes_sbox
    import aes_128_dec_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] inv;

    assign inv = gf_inv(a);
    assign s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse
module aes_inv_sbox
    import aes_128_dec_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] t;

    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign s = gf_inv(t);
endmodule

// One AES-128 key-schedule step: round key i from round key i-1
module key_schedule (
    input  logic [127:0] prev_key,
    input  logic [31:0]  rcon_word,
    output logic [127:0] next_key
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, tmp_w;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (.a(rot_w[8*i +: 8]), .s(sub_w[8*i +: 8]));
    end

    assign tmp_w    = sub_w ^ rcon_word;
    assign n0       = w0 ^ tmp_w;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};
endmodule

module aes_128_dec
    import aes_128_dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BLK_W-1:0] key,
    input  logic             key_load,
    output logic             key_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_bus
);
    dec_state_e       state_q, state_d;
    logic [RND_W-1:0] rnd_q;
    logic [7:0]       rcon_q;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] rk_tab [NR+1];

    logic key_go, exp_we, blk_go, rnd_en, out_go;

    logic [BLK_W-1:0]  ks_next;
    logic [15:0][7:0]  blk_b, isr_b, sub_b, ark_b, imc_b;
    logic [BLK_W-1:0]  round_out;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_NOKEY;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NOKEY:  if (key_load) state_d = S_EXPAND;
            S_EXPAND: if (rnd_q == RND_W'(NR)) state_d = S_IDLE;
            S_IDLE: begin
                if (key_load)      state_d = S_EXPAND;
                else if (in_valid) state_d = S_ROUND;
            end
            S_ROUND:  if (rnd_q == RND_W'(0)) state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_NOKEY;
        endcase
    end

    // Per-state strobes and the handshake ready; key_load outranks a block in IDLE
    always_comb begin
        key_go   = 1'b0;
        exp_we   = 1'b0;
        blk_go   = 1'b0;
        rnd_en   = 1'b0;
        out_go   = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            S_NOKEY:  key_go = key_load;
            S_EXPAND: exp_we = 1'b1;
            S_IDLE: begin
                key_go   = key_load;
                in_ready = ~key_load;
                blk_go   = in_valid & ~key_load;
            end
            S_ROUND:  rnd_en = 1'b1;
            S_DONE:   out_go = out_ready;
            default:  ;
        endcase
    end

    key_schedule u_ks (
        .prev_key  (rk_tab[RND_W'(rnd_q - RND_W'(1))]),
        .rcon_word ({rcon_q, 24'h000000}),
        .next_key  (ks_next)
    );

    // Round-key table: entry 0 takes the raw key, the rest fill in during EXPAND
    for (genvar i = 0; i <= NR; i++) begin : g_rk
        logic [BLK_W-1:0] q;
        if (i == 0) begin : g_k0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      q <= '0;
                else if (key_go) q <= key;
            end
        end else begin : g_kn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                            q <= '0;
                else if (exp_we && rnd_q == RND_W'(i)) q <= ks_next;
            end
        end
        assign rk_tab[i] = q;
    end

    // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
    assign blk_b = blk_q;
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign isr_b[15-(r+4*c)] = blk_b[15-(r+4*((c-r+4)%4))];
            aes_inv_sbox u_isb (.a(isr_b[15-(r+4*c)]), .s(sub_b[15-(r+4*c)]));
        end
        assign a0 = ark_b[15-4*c];
        assign a1 = ark_b[14-4*c];
        assign a2 = ark_b[13-4*c];
        assign a3 = ark_b[12-4*c];
        assign imc_b[15-4*c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign imc_b[14-4*c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign imc_b[13-4*c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign imc_b[12-4*c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    assign ark_b     = sub_b ^ rk_tab[rnd_q];
    assign round_out = (rnd_q == RND_W'(0)) ? BLK_W'(ark_b) : BLK_W'(imc_b);

    // Counters, block state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q     <= '0;
            rcon_q    <= '0;
            blk_q     <= '0;
            out_bus   <= '0;
            out_valid <= 1'b0;
            key_ready <= 1'b0;
        end else if (key_go) begin
            rcon_q    <= 8'h01;
            rnd_q     <= RND_W'(1);
            key_ready <= 1'b0;
        end else if (exp_we) begin
            rcon_q <= xtime(rcon_q);
            rnd_q  <= RND_W'(rnd_q + RND_W'(1));
            if (rnd_q == RND_W'(NR)) key_ready <= 1'b1;
        end else if (blk_go) begin
            blk_q <= in_bus ^ rk_tab[NR];
            rnd_q <= RND_W'(NR - 1);
        end else if (rnd_en) begin
            if (rnd_q != RND_W'(0)) begin
                blk_q <= round_out;
                rnd_q <= RND_W'(rnd_q - RND_W'(1));
            end else begin
                out_bus   <= round_out;
                out_valid <= 1'b1;
            end
        end else if (out_go) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_128_dec.sv
// Bench for aes_128_dec: FIPS-197 vectors, handshake corner cases and a
// random encrypt/decrypt round trip against a byte-level AES model.

module tb_aes_128_dec;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk, rst_n, key_load, key_ready, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] key, in_bus, out_bus;

    aes_128_dec dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_load(key_load), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_count = 0;
    int acc_cyc = 0;
    int prev_acc_cyc = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] mk  [11];
    logic [127:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural AES model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p, a;
        logic hi;
        p = 8'h00;
        a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    task automatic init_tables();
        logic [7:0] inv, s, xb, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(xb, 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x]  = s;
            isb[s] = xb;
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] v, input int b);
        return v[127-8*b -: 8];
    endfunction

    function automatic logic [127:0] sub_all(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv ? isb[gb(v, b)] : sb[gb(v, b)];
        return o;
    endfunction

    function automatic logic [127:0] shift(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = gb(v, r + 4*src);
            end
        return o;
    endfunction

    function automatic logic [7:0] coef(input bit inv, input int k);
        case (k)
            0: return inv ? 8'h0e : 8'h02;
            1: return inv ? 8'h0b : 8'h03;
            2: return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0] acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gm(coef(inv, (k - r + 4) % 4), gb(v, k + 4*c));
                o[127-8*(r+4*c) -: 8] = acc;
            end
        return o;
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ mk[0];
        for (int r = 1; r < 10; r++) s = mix(shift(sub_all(s, 0), 0), 0) ^ mk[r];
        return shift(sub_all(s, 0), 0) ^ mk[10];
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ mk[10];
        for (int r = 9; r >= 1; r--) s = mix(sub_all(shift(s, 1), 1) ^ mk[r], 1);
        return sub_all(shift(s, 1), 1) ^ mk[0];
    endfunction

    // Accept monitor feeds the scoreboard; every valid output is compared
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model_dec(in_bus));
            prev_acc_cyc = acc_cyc;
            acc_cyc      = cyc + 1;
            acc_count++;
        end
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_valid_without_block: got out_bus %h, want no output", out_bus);
            end else begin
                chk("out_bus_model", out_bus, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers (start and end at posedge+1) ----------------
    task automatic load_key(input logic [127:0] k, input bit chk_lat);
        int n;
        key      = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        model_expand(k);
        @(negedge clk);
        chk("key_ready_low_after_load", 128'(key_ready), 128'd0);
        n = 0;
        while (n < 40) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (key_ready) break;
        end
        if (chk_lat) chk("key_ready_latency", 128'(n), 128'd10);
        else if (!key_ready) chk("key_ready_timeout", 128'(key_ready), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_accept(input int start);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk); #1;
            n++;
            if (acc_count != start) break;
        end
        if (acc_count == start) chk("accept_timeout", 128'(acc_count), 128'(start + 1));
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input bit chk_lat);
        int n;
        n = 0;
        while (n < 60) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (chk_lat) chk("out_valid_latency", 128'(n), 128'd10);
        else if (!out_valid) chk("out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic send(input logic [127:0] ct, input bit lit_chk, input logic [127:0] lit, input bit chk_lat);
        int s;
        s        = acc_count;
        in_bus   = ct;
        in_valid = 1'b1;
        wait_accept(s);
        in_valid = 1'b0;
        wait_out(chk_lat);
        if (lit_chk) chk("plaintext_literal", out_bus, lit);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] held, rk, rp, rc;
        int s, kcyc;

        rst_n = 1'b0; key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        key = '0; in_bus = '0;

        // Pin the model to published values
        init_tables();
        chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        chk("model_isbox_63", 128'(isb[8'h63]), 128'h00);
        model_expand(KB);
        chk("model_rk10_b", mk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_dec_b", model_dec(CTB), PTB);
        model_expand(K1);
        chk("model_enc_c1", model_enc(PT1), CT1);

        // Reset values
        @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_bus", out_bus, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Block offered before any key is held off
        in_bus = CT1; in_valid = 1'b1; s = acc_count;
        repeat (3) begin
            @(negedge clk);
            chk("nokey_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("nokey_no_accept", 128'(acc_count), 128'(s));

        // FIPS-197 C.1 with latency checks
        load_key(K1, 1);
        send(CT1, 1, PT1, 1);
        @(negedge clk);
        chk("post_xfer_out_valid", 128'(out_valid), 128'd0);
        chk("post_xfer_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;

        // FIPS-197 B, then two blocks back to back under the same key
        load_key(KB, 1);
        send(CTB, 1, PTB, 1);
        in_bus = CTB; in_valid = 1'b1;
        s = acc_count; wait_accept(s);
        in_bus = CT1;
        s = acc_count; wait_accept(s);
        in_valid = 1'b0;
        chk("back_to_back_period", 128'(acc_cyc - prev_acc_cyc), 128'd12);
        wait_out(1);
        @(posedge clk); #1;

        // Backpressure: result held, no second accept
        out_ready = 1'b0;
        in_bus = CTB; in_valid = 1'b1;
        s = acc_count; wait_accept(s);
        in_valid = 1'b0;
        wait_out(1);
        held = out_bus;
        @(posedge clk); #1;
        in_bus = CT1; in_valid = 1'b1; s = acc_count;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_stable", out_bus, held);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
        end
        chk("bp_no_accept", 128'(acc_count), 128'(s));
        chk("bp_value", held, PTB);
        out_ready = 1'b1;
        wait_accept(s);
        in_valid = 1'b0;
        wait_out(1);
        @(posedge clk); #1;

        // key_load during ROUND is ignored
        in_bus = CTB; in_valid = 1'b1;
        s = acc_count; wait_accept(s);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        key = K1; key_load = 1'b1;
        @(posedge clk); #1 key_load = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("round_keyload_result", out_bus, PTB);
        chk("round_keyload_key_ready", 128'(key_ready), 128'd1);
        @(posedge clk); #1;

        // key_load with in_valid in IDLE: key wins, block waits for new key
        key = K1; key_load = 1'b1; in_bus = CT1; in_valid = 1'b1; s = acc_count;
        @(negedge clk);
        chk("kl_prio_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        kcyc = cyc;
        key_load = 1'b0;
        model_expand(K1);
        @(negedge clk);
        chk("kl_prio_key_ready", 128'(key_ready), 128'd0);
        chk("kl_prio_no_accept", 128'(acc_count), 128'(s));
        @(posedge clk); #1;
        wait_accept(s);
        in_valid = 1'b0;
        chk("kl_prio_accept_edge", 128'(acc_cyc - kcyc), 128'd11);
        wait_out(1);
        chk("kl_prio_result", out_bus, PT1);
        @(posedge clk); #1;

        // Reset in the middle of a decryption
        in_bus = CT1; in_valid = 1'b1;
        s = acc_count; wait_accept(s);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_key_ready", 128'(key_ready), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd0);
        chk("midrst_out_bus", out_bus, 128'd0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        load_key(K1, 1);
        send(CT1, 1, PT1, 1);

        // Random round trip through the model encryptor
        for (int i = 0; i < 1000; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            load_key(rk, 0);
            rc = model_enc(rp);
            send(rc, 1, rp, 0);
        end

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
